// File: rtl/button_array_debounce.sv
// Per-bit push-button debouncer: 2-flop synchronizer, stability counter, press/release pulses, sticky pending flags.
// Optional macro BUTTON_ARRAY_RELEASE_EVENT_EN enables the btn_release pulse logic; otherwise btn_release is tied to 0.
module button_array_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_n,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] btn_state,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Counter only advances while the synchronized level disagrees with the debounced state.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (~sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ~state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        press_d   = state_d & ~state_q;
        pending_d = press_d | (pending_q & ~ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            state_q   <= '0;
            press_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            pending_q <= pending_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef BUTTON_ARRAY_RELEASE_EVENT_EN
    logic [WIDTH-1:0] release_q, release_d;

    always_comb begin
        release_d = state_q & ~state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) release_q <= '0;
        else          release_q <= release_d;
    end

    assign btn_release = release_q;
`else
    assign btn_release = '0;
`endif

    assign btn_state = state_q;
    assign btn_press = press_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_button_array_debounce.sv
// Directed bench for button_array_debounce with WIDTH=3, DEBOUNCE_CYCLES=4.
// Expected btn_release follows BUTTON_ARRAY_RELEASE_EVENT_EN when the bench is built with it.
module tb_button_array_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] btn_n;
    logic [2:0] ack;
    logic [2:0] btn_state, btn_press, btn_release, pending;

    int checks = 0;
    int errors = 0;

    button_array_debounce #(
        .WIDTH(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_n(btn_n),
        .ack(ack),
        .btn_state(btn_state),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rel(input logic [2:0] v);
`ifdef BUTTON_ARRAY_RELEASE_EVENT_EN
        return v;
`else
        return 3'b000;
`endif
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Each step lands 1 time unit after a rising edge, away from the active edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] pr,
                             input logic [2:0] rl, input logic [2:0] pd);
        check({tag, ".state"},   btn_state,   st);
        check({tag, ".press"},   btn_press,   pr);
        check({tag, ".release"}, btn_release, rl);
        check({tag, ".pending"}, pending,     pd);
    endtask

    initial begin
        reset_n = 1'b0;
        btn_n   = 3'b111;
        ack     = 3'b000;
        #3;
        check_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        step(2);
        reset_n = 1'b1;
        step(3);
        check_all("idle", 3'b000, 3'b000, 3'b000, 3'b000);

        // Bit 0 pressed and held: toggles on the 6th edge.
        btn_n = 3'b110;
        step(5);
        check_all("p0_e5", 3'b000, 3'b000, 3'b000, 3'b000);
        step(1);
        check_all("p0_e6", 3'b001, 3'b001, 3'b000, 3'b001);
        step(1);
        check_all("p0_e7", 3'b001, 3'b000, 3'b000, 3'b001);
        step(5);
        check_all("p0_hold", 3'b001, 3'b000, 3'b000, 3'b001);

        // Bit 0 released.
        btn_n = 3'b111;
        step(5);
        check("r0_e5.state", btn_state, 3'b001);
        step(1);
        check_all("r0_e6", 3'b000, 3'b000, rel(3'b001), 3'b001);
        step(1);
        check("r0_e7.release", btn_release, 3'b000);

        // 3-cycle glitch on bit 1 must be filtered.
        btn_n = 3'b101;
        step(3);
        btn_n = 3'b111;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_all("glitch1", 3'b000, 3'b000, 3'b000, 3'b001);
        end

        // New press on bit 0 coincides with ack[0]: set wins.
        btn_n = 3'b110;
        step(5);
        check("ackset_e5.pending", pending, 3'b001);
        ack = 3'b001;
        step(1);
        check_all("ackset_e6", 3'b001, 3'b001, 3'b000, 3'b001);
        step(1);
        check("ack_only.pending", pending, 3'b000);
        ack = 3'b000;
        step(1);
        check("ack_done.pending", pending, 3'b000);

        // Bit 2 press then release while bit 0 stays held.
        btn_n = 3'b010;
        step(6);
        check_all("p2_e6", 3'b101, 3'b100, 3'b000, 3'b100);
        ack = 3'b100;
        step(1);
        check("ack2.pending", pending, 3'b000);
        ack = 3'b000;
        btn_n = 3'b110;
        step(5);
        check_all("r2_e5", 3'b101, 3'b000, 3'b000, 3'b000);
        step(1);
        check_all("r2_e6", 3'b001, 3'b000, rel(3'b100), 3'b000);
        step(1);
        check("r2_e7.release", btn_release, 3'b000);

        // Release all, then press bit 1 to have live state before reset.
        btn_n = 3'b111;
        step(6);
        check_all("rall_e6", 3'b000, 3'b000, rel(3'b001), 3'b000);
        btn_n = 3'b101;
        step(6);
        check_all("p1_e6", 3'b010, 3'b010, 3'b000, 3'b010);

        // Reset mid-count on bit 0: asynchronous clear, full latency afterwards.
        btn_n = 3'b100;
        step(3);
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        step(1);
        reset_n = 1'b1;
        step(5);
        check_all("post_rst_e5", 3'b000, 3'b000, 3'b000, 3'b000);
        step(1);
        check_all("post_rst_e6", 3'b011, 3'b011, 3'b000, 3'b011);

        // Release everything, then all three pressed at once.
        ack   = 3'b011;
        btn_n = 3'b111;
        step(1);
        ack = 3'b000;
        check("ack01.pending", pending, 3'b000);
        step(5);
        check_all("rall2_e6", 3'b000, 3'b000, rel(3'b011), 3'b000);
        btn_n = 3'b000;
        step(5);
        check("all_e5.state", btn_state, 3'b000);
        step(1);
        check_all("all_e6", 3'b111, 3'b111, 3'b000, 3'b111);
        step(1);
        check_all("all_e7", 3'b111, 3'b000, 3'b000, 3'b111);
        ack = 3'b111;
        step(1);
        check("ack_all.pending", pending, 3'b000);
        ack = 3'b000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
